// File: rtl/ps2_mouse_packet.sv
// ps2_mouse_packet
//   Frames the 3-byte PS/2 mouse stream packet out of the controller's
//   received-byte strobe, decodes buttons and 9-bit signed motion, and keeps
//   a clamped screen-space cursor. An inter-byte timeout drops a partial
//   packet so a lost byte cannot shift framing permanently.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   byte_in[7:0]  in   received byte
//   byte_valid    in   one-cycle strobe qualifying byte_in
//   recenter      in   load centre position (wins over a packet update)
//   packet_valid  out  one-cycle pulse, decoded outputs refreshed
//   buttons[2:0]  out  {middle, right, left}
//   dx[8:0]       out  signed X motion (0 on X overflow)
//   dy[8:0]       out  signed Y motion, up positive (0 on Y overflow)
//   x_pos         out  cursor X, 0..X_MAX
//   y_pos         out  cursor Y, down positive, 0..Y_MAX
//   sync_error    out  one-cycle pulse on discarded byte or timeout
module ps2_mouse_packet #(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int POS_W          = 10,
    parameter int X_MAX          = 639,
    parameter int Y_MAX          = 479
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             recenter,
    output logic             packet_valid,
    output logic [2:0]       buttons,
    output logic [8:0]       dx,
    output logic [8:0]       dy,
    output logic [POS_W-1:0] x_pos,
    output logic [POS_W-1:0] y_pos,
    output logic             sync_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Two extra bits: one for the carry past the top, one for sign.
    localparam int SUM_W = POS_W + 2;

    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [POS_W-1:0]        X_CTR    = POS_W'(X_MAX / 2);
    localparam logic [POS_W-1:0]        Y_CTR    = POS_W'(Y_MAX / 2);
    localparam logic signed [SUM_W-1:0] X_LIM    = SUM_W'(X_MAX);
    localparam logic signed [SUM_W-1:0] Y_LIM    = SUM_W'(Y_MAX);

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       b0;   // byte 0 minus its always-one sync bit
    logic [7:0]       b1;

    logic expired;
    logic load_b0, load_b1, pkt_done, sync_now, cnt_clr, cnt_inc;

    // A byte arriving in the expiry cycle is accepted, so expiry needs !byte_valid.
    assign expired = (state != WAIT_B0) && !byte_valid && (cnt == CNT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= WAIT_B0;
        else         state <= state_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            WAIT_B0: if (byte_valid && byte_in != 8'hFA && byte_in[3]) state_next = WAIT_B1;
            WAIT_B1: if (byte_valid) state_next = WAIT_B2;
                     else if (expired) state_next = WAIT_B0;
            WAIT_B2: if (byte_valid || expired) state_next = WAIT_B0;
            default: state_next = WAIT_B0;
        endcase
    end

    // ---------------- control outputs ----------------
    always_comb begin
        load_b0  = 1'b0;
        load_b1  = 1'b0;
        pkt_done = 1'b0;
        sync_now = 1'b0;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        case (state)
            WAIT_B0: begin
                cnt_clr = 1'b1;
                // ACK bytes from the init sequence are dropped without complaint.
                if (byte_valid && byte_in != 8'hFA) begin
                    if (byte_in[3]) load_b0  = 1'b1;
                    else            sync_now = 1'b1;
                end
            end
            WAIT_B1, WAIT_B2: begin
                if (byte_valid) begin
                    cnt_clr = 1'b1;
                    if (state == WAIT_B1) load_b1  = 1'b1;
                    else                  pkt_done = 1'b1;
                end else if (expired) begin
                    cnt_clr  = 1'b1;
                    sync_now = 1'b1;
                end else begin
                    cnt_inc  = 1'b1;
                end
            end
            default: cnt_clr = 1'b1;
        endcase
    end

    // ---------------- timeout counter / byte latches ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
            b0  <= '0;
            b1  <= '0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (load_b0) b0 <= {byte_in[7:4], byte_in[2:0]};
            if (load_b1) b1 <= byte_in;
        end
    end

    // ---------------- decode ----------------
    // b0 layout after dropping bit 3: [6]=Yovf [5]=Xovf [4]=Ysign [3]=Xsign [2:0]=buttons
    logic [8:0]             dx_new, dy_new;
    logic signed [SUM_W-1:0] x_sum, y_sum;
    logic [POS_W-1:0]       x_clamp, y_clamp;

    always_comb begin
        dx_new = b0[5] ? 9'd0 : {b0[3], b1};
        // Byte 2 is consumed straight off the bus on the cycle it arrives.
        dy_new = b0[6] ? 9'd0 : {b0[4], byte_in};

        x_sum = $signed({2'b00, x_pos}) + SUM_W'($signed(dx_new));
        // Mouse Y is up-positive, screen Y is down-positive.
        y_sum = $signed({2'b00, y_pos}) - SUM_W'($signed(dy_new));

        if (x_sum[SUM_W-1])    x_clamp = '0;
        else if (x_sum > X_LIM) x_clamp = POS_W'(X_MAX);
        else                    x_clamp = x_sum[POS_W-1:0];

        if (y_sum[SUM_W-1])    y_clamp = '0;
        else if (y_sum > Y_LIM) y_clamp = POS_W'(Y_MAX);
        else                    y_clamp = y_sum[POS_W-1:0];
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            packet_valid <= 1'b0;
            sync_error   <= 1'b0;
            buttons      <= '0;
            dx           <= '0;
            dy           <= '0;
            x_pos        <= X_CTR;
            y_pos        <= Y_CTR;
        end else begin
            packet_valid <= pkt_done;
            sync_error   <= sync_now;
            if (pkt_done) begin
                buttons <= b0[2:0];
                dx      <= dx_new;
                dy      <= dy_new;
            end
            if (recenter) begin
                x_pos <= X_CTR;
                y_pos <= Y_CTR;
            end else if (pkt_done) begin
                x_pos <= x_clamp;
                y_pos <= y_clamp;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Bench for ps2_mouse_packet: directed scenarios followed by random byte
// streams, all compared against a packet-level reference model.
module tb_ps2_mouse_packet;

    localparam int T     = 100;
    localparam int XM    = 639;
    localparam int YM    = 479;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic [7:0] byte_in  = 8'h00;
    logic       byte_valid = 1'b0;
    logic       recenter = 1'b0;
    logic       packet_valid, sync_error;
    logic [2:0] buttons;
    logic [8:0] dx, dy;
    logic [9:0] x_pos, y_pos;

    ps2_mouse_packet #(
        .TIMEOUT_CYCLES(T), .POS_W(10), .X_MAX(XM), .Y_MAX(YM)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .recenter    (recenter),
        .packet_valid(packet_valid),
        .buttons     (buttons),
        .dx          (dx),
        .dy          (dy),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .sync_error  (sync_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    // Pulse counters, sampled mid-cycle.
    int pv_seen = 0, se_seen = 0, both_seen = 0;
    always @(negedge CLOCK_50) begin
        if (packet_valid === 1'b1) pv_seen++;
        if (sync_error === 1'b1) se_seen++;
        if (packet_valid === 1'b1 && sync_error === 1'b1) both_seen++;
    end

    // Reference model: packet-level view of the byte stream.
    int         m_idx, m_btn, m_dx, m_dy, m_x, m_y;
    int         m_pv = 0, m_se = 0;
    logic [7:0] m_pkt [3];

    function automatic int clamp(input int v, input int hi);
        if (v < 0)  return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("buttons", {29'd0, buttons}, m_btn);
        chk("dx", {23'd0, dx}, m_dx & 'h1FF);
        chk("dy", {23'd0, dy}, m_dy & 'h1FF);
        chk("x_pos", {22'd0, x_pos}, m_x);
        chk("y_pos", {22'd0, y_pos}, m_y);
    endtask

    task automatic model_reset();
        m_idx = 0; m_btn = 0; m_dx = 0; m_dy = 0;
        m_x = XM / 2; m_y = YM / 2;
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        byte_valid = 1'b0;
        recenter   = 1'b0;
        resetn     = 1'b0;
        model_reset();
        #1;
        // Asynchronous: values must already be at reset before any edge.
        chk("rst_pv", {31'd0, packet_valid}, 0);
        chk("rst_se", {31'd0, sync_error}, 0);
        chk_outs();
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    task automatic idle(input int g);
        repeat (g) @(posedge CLOCK_50);
        if (m_idx != 0 && g >= T) begin
            m_idx = 0;
            m_se++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic r, input int gap);
        int exp_pv, exp_se;
        @(negedge CLOCK_50);
        #1;
        chk("pv_count", pv_seen, m_pv);
        chk("se_count", se_seen, m_se);
        byte_in    = b;
        byte_valid = 1'b1;
        recenter   = r;
        @(posedge CLOCK_50);
        #1;
        byte_valid = 1'b0;
        recenter   = 1'b0;

        exp_pv = 0;
        exp_se = 0;
        if (m_idx == 0) begin
            if (b == 8'hFA) begin
            end else if (!b[3]) begin
                exp_se = 1;
            end else begin
                m_pkt[0] = b;
                m_idx = 1;
            end
        end else if (m_idx == 1) begin
            m_pkt[1] = b;
            m_idx = 2;
        end else begin
            m_pkt[2] = b;
            m_idx = 0;
            exp_pv = 1;
            m_btn = m_pkt[0] & 7;
            m_dx = m_pkt[0][6] ? 0 : int'(m_pkt[1]) - (m_pkt[0][4] ? 256 : 0);
            m_dy = m_pkt[0][7] ? 0 : int'(m_pkt[2]) - (m_pkt[0][5] ? 256 : 0);
            m_x = clamp(m_x + m_dx, XM);
            m_y = clamp(m_y - m_dy, YM);
        end
        if (r) begin
            m_x = XM / 2;
            m_y = YM / 2;
        end
        m_pv += exp_pv;
        m_se += exp_se;

        chk("packet_valid", {31'd0, packet_valid}, exp_pv);
        chk("sync_error", {31'd0, sync_error}, exp_se);
        chk_outs();
        idle(gap);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b0, 3);
        send_byte(b, 1'b0, 3);
        send_byte(c, 1'b0, 3);
    endtask

    initial begin
        logic [7:0] rb;
        int         gap;
        model_reset();

        do_reset();
        send_pkt(8'h08, 8'h10, 8'hF0);

        do_reset();
        send_pkt(8'h09, 8'h00, 8'h00);

        // Leftward motion walks x down and clamps at 0.
        do_reset();
        repeat (3) send_pkt(8'h18, 8'h80, 8'h00);

        // ACK ignored, bad sync byte flagged, next packet clean.
        send_byte(8'hFA, 1'b0, 3);
        send_byte(8'h00, 1'b0, 3);
        send_pkt(8'h08, 8'h01, 8'h01);

        // Timeout mid-packet.
        send_byte(8'h08, 1'b0, 3);
        send_byte(8'h05, 1'b0, T + 5);
        send_pkt(8'h08, 8'h02, 8'h02);

        // Byte arriving in the expiry cycle is accepted.
        send_byte(8'h08, 1'b0, T - 1);
        send_byte(8'h04, 1'b0, 3);
        send_byte(8'h04, 1'b0, 3);
        // One cycle later it is too late: timeout, then the byte restarts framing.
        send_byte(8'h08, 1'b0, T);
        send_byte(8'h28, 1'b0, 3);
        send_byte(8'h06, 1'b0, 3);
        send_byte(8'h06, 1'b0, 3);

        // X overflow zeroes dx; recenter on the update edge wins over motion.
        send_byte(8'h48, 1'b0, 3);
        send_byte(8'h7F, 1'b0, 3);
        send_byte(8'h00, 1'b1, 3);

        // Reset mid-packet discards it.
        send_byte(8'h08, 1'b0, 3);
        do_reset();
        send_pkt(8'h08, 8'h03, 8'h03);

        // Random streams.
        for (int i = 0; i < 400; i++) begin
            rb = 8'($urandom);
            if (m_idx == 0) begin
                if ($urandom_range(0, 9) < 8) rb[3] = 1'b1;
                if ($urandom_range(0, 19) == 0) rb = 8'hFA;
            end
            gap = $urandom_range(1, 15);
            if ($urandom_range(0, 39) == 0) gap = T + $urandom_range(0, 3);
            send_byte(rb, $urandom_range(0, 19) == 0, gap);
        end

        idle(3);
        @(negedge CLOCK_50);
        #1;
        chk("pv_count_end", pv_seen, m_pv);
        chk("se_count_end", se_seen, m_se);
        chk("pv_se_overlap", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
